// File: rtl/router_pkg.sv
// Shared types for the 1x3 router control path: FSM state codes and port addresses.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    CHECK_PARITY_ERROR = 3'd4,
    LOAD_PARITY        = 3'd5,
    FIFO_FULL_STATE    = 3'd6,
    LOAD_AFTER_FULL    = 3'd7
  } state_t;

  localparam logic [1:0] ADDR0 = 2'd0;
  localparam logic [1:0] ADDR1 = 2'd1;
  localparam logic [1:0] ADDR2 = 2'd2;

endpackage

// File: rtl/fsm.sv
// Router control FSM: decodes the header address, sequences header/payload/parity
// loading, handles FIFO-full stalls and per-port soft resets. Moore outputs only.
module fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       packet_valid,
  input  logic [1:0] datain,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       lfd_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy,
  output logic [2:0] current_state
);

  state_t     state, next_state;
  logic [1:0] addr;
  logic       soft_hit;
  logic       empty_in;
  logic       empty_latched;

  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= DECODE_ADDRESS;
      addr  <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && packet_valid)
        addr <= datain;
    end
  end

  // Soft reset is qualified by the latched address, so a reset on an idle
  // port never disturbs a packet in flight to another port.
  always_comb begin
    soft_hit = (soft_reset_0 && addr == ADDR0) ||
               (soft_reset_1 && addr == ADDR1) ||
               (soft_reset_2 && addr == ADDR2);
  end

  always_comb begin
    empty_in = 1'b0;
    case (datain)
      ADDR0:   empty_in = fifo_empty_0;
      ADDR1:   empty_in = fifo_empty_1;
      ADDR2:   empty_in = fifo_empty_2;
      default: empty_in = 1'b0;
    endcase
  end

  always_comb begin
    empty_latched = 1'b0;
    case (addr)
      ADDR0:   empty_latched = fifo_empty_0;
      ADDR1:   empty_latched = fifo_empty_1;
      ADDR2:   empty_latched = fifo_empty_2;
      default: empty_latched = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    if (soft_hit) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (packet_valid && datain != 2'd3)
            next_state = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:
          next_state = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)          next_state = FIFO_FULL_STATE;
          else if (!packet_valid) next_state = LOAD_PARITY;
        LOAD_PARITY:
          next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        FIFO_FULL_STATE:
          if (!fifo_full) next_state = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)           next_state = DECODE_ADDRESS;
          else if (low_packet_valid) next_state = LOAD_PARITY;
          else                       next_state = LOAD_DATA;
        WAIT_TILL_EMPTY:
          if (empty_latched) next_state = LOAD_FIRST_DATA;
        default:
          next_state = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                    (state == LOAD_AFTER_FULL);
    busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    current_state = state;
  end

endmodule

// File: tb/tb_fsm.sv
// Directed self-checking bench for the router control FSM.
module tb_fsm;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       packet_valid = 1'b0;
  logic [1:0] datain = '0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b0, fifo_empty_1 = 1'b0, fifo_empty_2 = 1'b0;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_packet_valid = 1'b0;
  logic       write_enb_reg, detect_add, ld_state, laf_state, lfd_state;
  logic       full_state, rst_int_reg, busy;
  logic [2:0] current_state;

  int checks = 0;
  int errors = 0;

  fsm dut (
    .clk(clk), .resetn(resetn), .packet_valid(packet_valid), .datain(datain),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .write_enb_reg(write_enb_reg),
    .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
    .lfd_state(lfd_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .busy(busy), .current_state(current_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_state(input string tag, input logic [2:0] exp);
    step();
    check(tag, {29'd0, current_state}, {29'd0, exp});
  endtask

  initial begin
    resetn = 1'b1;
    step();
    resetn = 1'b0;
    check("rst_state", {29'd0, current_state}, 32'd0);
    check("rst_detect_add", {31'd0, detect_add}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wenb", {31'd0, write_enb_reg}, 32'd0);
    check("rst_others", {27'd0, ld_state, laf_state, lfd_state, full_state, rst_int_reg}, 32'd0);

    // normal packet to port 0, 3 payload cycles
    fifo_empty_0 = 1'b1; packet_valid = 1'b1; datain = 2'd0;
    step_state("np_lfd", 3'd1);
    check("np_lfd_strobe", {31'd0, lfd_state}, 32'd1);
    check("np_lfd_busy", {31'd0, busy}, 32'd1);
    check("np_lfd_wenb", {31'd0, write_enb_reg}, 32'd0);
    step_state("np_ld1", 3'd2);
    check("np_ld_wenb", {31'd0, write_enb_reg}, 32'd1);
    check("np_ld_busy", {31'd0, busy}, 32'd0);
    check("np_ld_strobe", {31'd0, ld_state}, 32'd1);
    check("np_lfd_gone", {31'd0, lfd_state}, 32'd0);
    step_state("np_ld2", 3'd2);
    step_state("np_ld3", 3'd2);
    packet_valid = 1'b0;
    step_state("np_lp", 3'd5);
    check("np_lp_wenb", {31'd0, write_enb_reg}, 32'd1);
    check("np_lp_busy", {31'd0, busy}, 32'd1);
    step_state("np_cpe", 3'd4);
    check("np_cpe_rst_int", {31'd0, rst_int_reg}, 32'd1);
    check("np_cpe_wenb", {31'd0, write_enb_reg}, 32'd0);
    step_state("np_da", 3'd0);
    check("np_da_rst_int", {31'd0, rst_int_reg}, 32'd0);
    step_state("np_idle", 3'd0);

    // busy destination
    fifo_empty_0 = 1'b0; packet_valid = 1'b1; datain = 2'd0;
    step_state("wte", 3'd3);
    check("wte_busy", {31'd0, busy}, 32'd1);
    step_state("wte_hold", 3'd3);
    fifo_empty_0 = 1'b1;
    step_state("wte_lfd", 3'd1);
    step_state("wte_ld", 3'd2);

    // fifo full mid-payload
    fifo_full = 1'b1;
    step_state("ff_full", 3'd6);
    check("ff_full_strobe", {31'd0, full_state}, 32'd1);
    check("ff_busy", {31'd0, busy}, 32'd1);
    check("ff_wenb", {31'd0, write_enb_reg}, 32'd0);
    step_state("ff_hold", 3'd6);
    fifo_full = 1'b0;
    step_state("ff_laf", 3'd7);
    check("ff_laf_strobe", {31'd0, laf_state}, 32'd1);
    check("ff_laf_wenb", {31'd0, write_enb_reg}, 32'd1);
    low_packet_valid = 1'b1;
    step_state("laf_lp", 3'd5);
    low_packet_valid = 1'b0;
    step_state("laf_cpe", 3'd4);
    packet_valid = 1'b0;
    step_state("laf_da", 3'd0);

    packet_valid = 1'b1; datain = 2'd0;
    step_state("p2_lfd", 3'd1);
    step_state("p2_ld", 3'd2);
    fifo_full = 1'b1;
    step_state("p2_full", 3'd6);
    fifo_full = 1'b0;
    step_state("p2_laf", 3'd7);
    step_state("laf_ld", 3'd2);
    fifo_full = 1'b1;
    step_state("p2_full2", 3'd6);
    fifo_full = 1'b0;
    step_state("p2_laf2", 3'd7);
    parity_done = 1'b1; packet_valid = 1'b0;
    step_state("laf_pd_da", 3'd0);
    parity_done = 1'b0;

    // soft reset on port 1
    packet_valid = 1'b1; datain = 2'd1; fifo_empty_1 = 1'b1;
    step_state("sr_lfd", 3'd1);
    step_state("sr_ld", 3'd2);
    soft_reset_2 = 1'b1;
    step_state("sr_other_port", 3'd2);
    soft_reset_2 = 1'b0; soft_reset_1 = 1'b1;
    step_state("sr_hit", 3'd0);
    soft_reset_1 = 1'b0; packet_valid = 1'b0;
    step_state("sr_idle", 3'd0);

    // invalid address, then fifo full after parity
    packet_valid = 1'b1; datain = 2'd3;
    step_state("inv_stay1", 3'd0);
    step_state("inv_stay2", 3'd0);
    check("inv_detect_add", {31'd0, detect_add}, 32'd1);
    datain = 2'd0;
    step_state("cf_lfd", 3'd1);
    step_state("cf_ld", 3'd2);
    packet_valid = 1'b0;
    step_state("cf_lp", 3'd5);
    step_state("cf_cpe", 3'd4);
    fifo_full = 1'b1;
    step_state("cf_full", 3'd6);
    fifo_full = 1'b0;
    step_state("cf_laf", 3'd7);
    parity_done = 1'b1;
    step_state("cf_da", 3'd0);
    parity_done = 1'b0;

    // reset mid-packet wins over everything
    packet_valid = 1'b1;
    step_state("mr_lfd", 3'd1);
    resetn = 1'b1;
    step_state("mr_reset", 3'd0);
    resetn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
